// File: rtl/mul_pkg.sv
// Shared types and sizing for the radix-4 Booth multiplier controller.
package mul_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PROD_W   = 64;
    localparam int unsigned N_DIGITS = 17;
    // {ext2(rs2), 1'b0}: two extension bits, the operand, and the implicit bit -1
    localparam int unsigned MPLIER_W = XLEN + 3;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth digit selector: maps a 3-bit multiplier window to 0, +-a or +-2a.
module booth_encoder
    import mul_pkg::*;
(
    input  logic [PROD_W-1:0] a,
    input  logic [2:0]        b,
    output logic [PROD_W-1:0] pp_temp
);

    // Partial product for the current Booth window
    always_comb begin
        pp_temp = '0;
        case (b)
            3'b001, 3'b010: pp_temp = a;
            3'b011:         pp_temp = a << 1;
            3'b100:         pp_temp = ~(a << 1) + PROD_W'(1);
            3'b101, 3'b110: pp_temp = ~a + PROD_W'(1);
            default:        pp_temp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One Booth digit per cycle; result held until the consumer takes it.
module booth_mul_ctrl
    import mul_pkg::*;
#(
    parameter bit          EARLY_OUT = 1'b1,
    parameter int unsigned N_DIGITS  = mul_pkg::N_DIGITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    mul_state_t state, state_nxt;

    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   acc;
    logic [MPLIER_W-1:0] mplier;
    logic [CNT_W-1:0]    cnt;
    logic                sel_hi;

    logic [PROD_W-1:0]   pp_temp;
    logic [PROD_W-1:0]   acc_sum_c;
    mul_op_t             op_c;
    logic                accept_c;
    logic                zero_c;
    logic                last_digit_c;
    logic                rs1_signed_c;
    logic                rs2_signed_c;

    logic                req_ready_nxt;
    logic                resp_valid_nxt;
    logic                busy_nxt;
    logic [XLEN-1:0]     result_nxt;

    booth_encoder u_booth_encoder (
        .a       (mcand),
        .b       (mplier[2:0]),
        .pp_temp (pp_temp)
    );

    // Request decode, operand classification and accumulator adder
    always_comb begin
        accept_c     = req_valid && req_ready && !flush;
        op_c         = funct3[2] ? MUL : mul_op_t'(funct3);
        rs1_signed_c = (op_c != MULHU);
        rs2_signed_c = (op_c == MUL) || (op_c == MULH);
        zero_c       = EARLY_OUT && ((rs1 == '0) || (rs2 == '0));
        last_digit_c = (cnt == CNT_W'(N_DIGITS - 1));
        acc_sum_c    = acc + pp_temp;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response only retires once resp_valid is actually presented
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = zero_c ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last_digit_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush || (resp_valid && resp_ready)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output next values; an early-out spends its first DONE cycle before presenting
    always_comb begin
        req_ready_nxt  = (state_nxt == IDLE);
        busy_nxt       = (state_nxt != IDLE);
        resp_valid_nxt = (state_nxt == DONE) && (state != IDLE);
        result_nxt     = result;
        if ((state == CALC) && (state_nxt == DONE)) begin
            result_nxt = sel_hi ? acc_sum_c[PROD_W-1:XLEN] : acc_sum_c[XLEN-1:0];
        end else if ((state == IDLE) && (state_nxt == DONE)) begin
            result_nxt = '0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
        end else begin
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            busy       <= busy_nxt;
            result     <= result_nxt;
        end
    end

    // Operand latch on accept, then one Booth digit retired per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sel_hi <= 1'b0;
        end else if (accept_c) begin
            mcand  <= {{XLEN{rs1_signed_c & rs1[XLEN-1]}}, rs1};
            mplier <= {{2{rs2_signed_c & rs2[XLEN-1]}}, rs2, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            sel_hi <= (op_c != MUL);
        end else if (state == CALC) begin
            acc    <= acc_sum_c;
            mcand  <= mcand << 2;
            mplier <= {{2{mplier[MPLIER_W-1]}}, mplier[MPLIER_W-1:2]};
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: two instances (early-out on/off) share stimulus.
module tb_booth_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        resp_ready;

    logic        req_ready,  resp_valid,  busy;
    logic [31:0] result;
    logic        req_ready0, resp_valid0, busy0;
    logic [31:0] result0;

    int n_assert = 0;
    int n_fail   = 0;

    booth_mul_ctrl #(.EARLY_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    booth_mul_ctrl #(.EARLY_OUT(1'b0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready0),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready),
        .result     (result0),
        .busy       (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend both operands to 64 bits and multiply
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (f == 3'b000 || f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to both instances; check latency (accept cycle = 0) and result
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r);
        int  lat, lat0, exp_lat;
        logic [31:0] res, res0;
        bit  got, got0;
        exp_lat = ((a == 32'h0) || (b == 32'h0)) ? 2 : 18;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " req_ready0"}, 32'(req_ready0), 32'd1);
        req_valid = 1'b1;
        funct3    = f;
        rs1       = a;
        rs2       = b;
        wait_cycle();
        req_valid = 1'b0;
        funct3    = 3'($urandom);
        rs1       = $urandom;
        rs2       = $urandom;
        check({tag, " busy"}, 32'(busy0), 32'd1);
        got = 1'b0; got0 = 1'b0; lat = 0; lat0 = 0; res = '0; res0 = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (resp_valid && !got) begin
                got = 1'b1; lat = cyc; res = result;
            end
            if (resp_valid0 && !got0) begin
                got0 = 1'b1; lat0 = cyc; res0 = result0;
            end
            if (got && got0) break;
            wait_cycle();
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " latency(no early-out)"}, 32'(lat0), 32'd18);
        check({tag, " result"}, res, exp_r);
        check({tag, " result(no early-out)"}, res0, exp_r);
        wait_cycle();
    endtask

    initial begin
        bit          got;
        bit          saw;
        logic [2:0]  f;
        logic [31:0] a, b;

        rst = 1'b1; req_valid = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
        flush = 1'b0; resp_ready = 1'b1;
        repeat (3) wait_cycle();
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_cycle();

        // Directed products
        do_op("mul 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mul max*max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("mulhsu -1*umax", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhu 0*x", 3'b011, 32'h0, 32'h1234_5678, 32'h0);
        do_op("mulh x*0", 3'b001, 32'h8765_4321, 32'h0, 32'h0);

        // Randomised products against the reference model
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            do_op($sformatf("rand%0d f%0d", i, f), f, a, b, ref_result(f, a, b));
        end

        // Backpressure: result held while resp_ready is low, new requests ignored
        resp_ready = 1'b0;
        req_valid = 1'b1; funct3 = 3'b001; rs1 = 32'h8000_0000; rs2 = 32'h8000_0000;
        wait_cycle();
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else wait_cycle();
        end
        check("bp resp_valid seen", 32'(got), 32'd1);
        req_valid = 1'b1; funct3 = 3'b000; rs1 = $urandom; rs2 = $urandom;
        for (int i = 0; i < 5; i++) begin
            wait_cycle();
            check("bp hold resp_valid", 32'(resp_valid), 32'd1);
            check("bp hold result", result, 32'h4000_0000);
            check("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        wait_cycle();
        check("bp release resp_valid", 32'(resp_valid), 32'd0);
        check("bp release busy", 32'(busy), 32'd0);
        do_op("bp next mulhu", 3'b011, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D);

        // Flush at CALC cycle 8
        req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0;
        wait_cycle();
        req_valid = 1'b0;
        repeat (7) wait_cycle();
        flush = 1'b1;
        wait_cycle();
        flush = 1'b0;
        check("flush req_ready", 32'(req_ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        check("flush resp_valid", 32'(resp_valid), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            wait_cycle();
            if (resp_valid || resp_valid0) saw = 1'b1;
        end
        check("flush no response", 32'(saw), 32'd0);

        // Flush in IDLE wins over a request
        req_valid = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
        wait_cycle();
        req_valid = 1'b0; flush = 1'b0;
        check("idle flush busy", 32'(busy), 32'd0);
        check("idle flush req_ready", 32'(req_ready), 32'd1);

        // Asynchronous reset mid-CALC
        req_valid = 1'b1; funct3 = 3'b011; rs1 = 32'hCAFE_F00D; rs2 = 32'h0BAD_1DEA;
        wait_cycle();
        req_valid = 1'b0;
        repeat (5) wait_cycle();
        #2 rst = 1'b1;
        #1;
        check("async rst req_ready", 32'(req_ready), 32'd1);
        check("async rst busy", 32'(busy), 32'd0);
        wait_cycle();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            wait_cycle();
            if (resp_valid || resp_valid0) saw = 1'b1;
        end
        check("rst no response", 32'(saw), 32'd0);
        check("rst idle req_ready", 32'(req_ready), 32'd1);
        do_op("mul 3*5", 3'b000, 32'd3, 32'd5, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
Iterative radix-4 Booth multiplier controller for the RV32M MUL/MULH/MULHSU/MULHU instructions in the EX stage. It accepts one request through a valid/ready handshake and performs one Booth digit per cycle through a single booth_encoder instance and a 64-bit accumulator. It holds the 32-bit result until the pipeline takes it. It supports a flush abort and an early-out path for zero operands.

Parameters:
EARLY_OUT, 1, 1 = a zero rs1 or rs2 skips the CALC state (result 0 after one cycle); 0 = always full latency.
N_DIGITS, 17, number of Booth digits retired, equal to (XLEN+2)/2 for 34-bit extended operands. Fixed for XLEN=32; any other value is illegal.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block idle and can accept a request
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is illegal
rs1  input  32  multiplicand
rs2  input  32  multiplier
flush  input  1  abort the in-flight operation
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts the result
result  output  32  MUL: product[31:0]; all other opcodes: product[63:32]
busy  output  1  state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE. req_ready=1, resp_valid=0, result=0, busy=0. All internal registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE, on req_valid && req_ready: latch the operands.
  - mcand: 64 bits, rs1 sign-extended for MUL/MULH/MULHSU, zero-extended for MULHU.
  - mplier: 35 bits = {ext2(rs2), 1'b0}. rs2 is sign-extended to 34 bits for MUL/MULH and zero-extended for MULHSU/MULHU.
  - acc=0, cnt=0, sel_hi = (funct3!=000).
  - Next state is CALC, or DONE with acc=0 when EARLY_OUT && (rs1==0 || rs2==0).
- CALC, each cycle:
  - The encoder receives a=mcand and b=mplier[2:0].
  - Update acc += pp_temp (mod 2^64), mcand <<= 2, mplier >>= 2 (arithmetic shift), cnt++.
  - After the digit with cnt==N_DIGITS-1, go to DONE.
  - Latency from accept to resp_valid is exactly 18 cycles (17 CALC + 1), or 2 cycles on early-out.
- DONE:
  - resp_valid=1; result = sel_hi ? acc[63:32] : acc[31:0]. The result is registered and stable while resp_valid=1 && !resp_ready.
  - On resp_ready, go to IDLE. A new request can be accepted on the following cycle; there is no same-cycle back-to-back accept.
- req_ready=1 only in IDLE. req_valid is ignored in the other states. Operands must not be sampled outside the accept edge.
- flush:
  - In CALC or DONE: next state is IDLE and resp_valid drops the next cycle. The result is discarded.
  - In IDLE, flush has priority over req_valid; nothing is accepted that cycle.
  - flush and resp_ready in the same DONE cycle: go to IDLE. The response counts as not delivered.
- funct3 1xx at accept: treated as MUL. Verification must not rely on this behaviour.
- Reset mid-CALC: the operation is lost, and the block is back in IDLE with req_ready=1 after reset deasserts.

Decomposition:
- Package mul_pkg:
  - typedef enum mul_op_t {MUL, MULH, MULHSU, MULHU} (3-bit, encoded to match funct3)
  - typedef enum mul_state_t {IDLE, CALC, DONE}
  - localparams XLEN=32, PROD_W=64, N_DIGITS=17
- Sub-module: the existing booth_encoder (64-bit a, 3-bit b, 64-bit pp_temp), instantiated once. All sequencing, extension and accumulation stay in booth_mul_ctrl.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), resp_ready=1 -> resp_valid exactly 18 cycles after accept, result=0xFFFFFFEB.
- MULH rs1=rs2=0x80000000 -> result=0x40000000. MULHU rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MUL with the same operands -> result=0x00000001.
- MULHSU rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF (unsigned) -> result=0xFFFFFFFF, i.e. product 0xFFFFFFFF_00000001.
- EARLY_OUT=1: MULHU rs1=0, rs2=0x12345678 -> resp_valid 2 cycles after accept, result=0. With EARLY_OUT=0 -> 18 cycles, result=0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> resp_valid and result stay stable and req_ready=0. Assert resp_ready -> IDLE next cycle, and a second request is accepted 1 cycle later.
- flush at CALC cycle 8, then async rst pulse mid-CALC on a second operation -> both go to IDLE, no resp_valid, req_ready=1. A subsequent MUL 3*5 returns 0x0000000F.
